// File: rtl/bram_stream_reader_if.sv
// rtl/bram_stream_reader_if.sv - command, BRAM read port and output stream bundle for bram_stream_reader
// cmd_stride exists only when BRAM_STREAM_READER_STRIDE_EN is defined.
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef BRAM_STREAM_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] cmd_stride;
`endif
    logic                  rden;
    logic                  wren;
    logic [STRB_WIDTH-1:0] wrstrb;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dack;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
`ifdef BRAM_STREAM_READER_STRIDE_EN
        input  cmd_stride,
`endif
        input  dout, dack, m_axis_tready,
        output cmd_ready, rden, wren, wrstrb, addr, din,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
`ifdef BRAM_STREAM_READER_STRIDE_EN
        output cmd_stride,
`endif
        output dout, dack, m_axis_tready,
        input  cmd_ready, rden, wren, wrstrb, addr, din,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, done
    );
endinterface

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - burst reader of one BRAM port re-emitted as a backpressured stream
// BRAM_STREAM_READER_STRIDE_EN adds a per-command address stride (otherwise stride is 1).
module bram_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    bram_stream_reader_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, next_addr_q, stride_q, stride_in;
    logic [LEN_WIDTH-1:0]  remaining_q, len_q, beats_q;
    logic [CW-1:0]         outstanding_q, outstanding_d, count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  rden_q;
    logic                  accept, issue, credit_ok, push, pop, tvalid, tlast;

`ifdef BRAM_STREAM_READER_STRIDE_EN
    assign stride_in = bus.cmd_stride;
`else
    assign stride_in = ADDR_WIDTH'(1);
`endif

    // A word is only launched when a FIFO slot is already reserved for it.
    assign credit_ok     = ({1'b0, outstanding_q} + {1'b0, count_q}) < CREDITS;
    assign accept        = (state_q == IDLE) && bus.cmd_valid;
    assign issue         = (state_q == READ) && credit_ok;
    assign push          = bus.dack && (outstanding_q != '0);
    assign tvalid        = (count_q != '0);
    assign pop           = tvalid && bus.m_axis_tready;
    assign tlast         = tvalid && (beats_q == len_q);
    assign outstanding_d = outstanding_q + CW'(accept | issue) - CW'(push);
    assign count_d       = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.dout;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            next_addr_q   <= '0;
            stride_q      <= '0;
            remaining_q   <= '0;
            len_q         <= '0;
            beats_q       <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rden_q        <= 1'b0;
        end else begin
            rden_q        <= accept | issue;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                beats_q  <= beats_q + LEN_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    // The first word is launched on the accept edge itself.
                    if (accept) begin
                        addr_q      <= bus.cmd_addr;
                        next_addr_q <= bus.cmd_addr + stride_in;
                        stride_q    <= stride_in;
                        len_q       <= bus.cmd_len;
                        remaining_q <= bus.cmd_len;
                        beats_q     <= '0;
                        state_q     <= (bus.cmd_len == '0) ? DRAIN : READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q      <= next_addr_q;
                        next_addr_q <= next_addr_q + stride_q;
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && tlast) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready     = (state_q == IDLE);
    assign bus.rden          = rden_q;
    assign bus.addr          = addr_q;
    assign bus.wren          = 1'b0;
    assign bus.wrstrb        = '0;
    assign bus.din           = '0;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = tvalid ? mem_q[rd_ptr_q] : '0;
    assign bus.m_axis_tlast  = tlast;
    assign bus.done          = pop && tlast;
endmodule
